// File: rtl/hazard_pkg.sv
// Shared types and defaults for the Decode->Execute hazard controller.
package hazard_pkg;

    localparam int unsigned NUM_REGS_DEF   = 16;
    localparam int unsigned PEND_W_DEF     = 2;
    localparam int unsigned BR_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BR_PEND = 2'd1,
        ST_FLUSH   = 2'd2
    } br_state_e;

    // Timeout counter must be able to hold the value BR_TIMEOUT itself.
    function automatic int unsigned to_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/hazard_pend_counter.sv
// Saturating up/down counter of in-flight writes to one register; updates on negedge.
module hazard_pend_counter
    import hazard_pkg::*;
#(
    parameter int unsigned W = PEND_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_busy,
    output logic         o_full
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;

    assign o_cnt  = r_cnt;
    assign o_busy = |r_cnt;
    assign o_full = &r_cnt;

    // Simultaneous inc/dec cancel; never wrap in either direction.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_inc && !i_dec && !o_full) begin
            w_cnt_nxt = r_cnt + W'(1);
        end else if (i_dec && !i_inc && o_busy) begin
            w_cnt_nxt = r_cnt - W'(1);
        end
    end

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Issue hazard controller: register scoreboard plus branch hold/flush FSM.
// HAZARD_BR_PREDICT_EN: predict not-taken, so Fetch is not held while a branch is pending.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
    parameter int unsigned PEND_W     = PEND_W_DEF,
    parameter int unsigned BR_TIMEOUT = BR_TIMEOUT_DEF
) (
    input  logic                        I_CLOCK,
    input  logic                        I_RESET_N,
    input  logic                        I_IssueValid,
    input  logic [$clog2(NUM_REGS)-1:0] I_IssueSrc1Idx,
    input  logic [$clog2(NUM_REGS)-1:0] I_IssueSrc2Idx,
    input  logic                        I_IssueSrc1Used,
    input  logic                        I_IssueSrc2Used,
    input  logic [$clog2(NUM_REGS)-1:0] I_IssueDestIdx,
    input  logic                        I_IssueDestWr,
    input  logic                        I_IssueIsBranch,
    input  logic                        I_WBValid,
    input  logic [$clog2(NUM_REGS)-1:0] I_WBDestIdx,
    input  logic                        I_BrResolve,
    input  logic                        I_BrTaken,
    output logic                        O_IssueGrant,
    output logic                        O_DepStall,
    output logic                        O_FetchStall,
    output logic                        O_Flush,
    output logic [NUM_REGS-1:0]         O_Busy,
    output logic                        O_BrTimeout
);

    localparam int unsigned     IDX_W  = $clog2(NUM_REGS);
    localparam int unsigned     TO_W   = to_width(BR_TIMEOUT);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(BR_TIMEOUT);

    br_state_e           r_state;
    br_state_e           w_state_nxt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [TO_W-1:0]     w_to_cnt_nxt;
    logic [TO_W-1:0]     w_to_inc;
    logic                r_timeout;
    logic                w_timeout_nxt;

    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_full;
    logic [PEND_W-1:0]   w_cnt [NUM_REGS];

    logic                w_src1_haz;
    logic                w_src2_haz;
    logic                w_dest_haz;
    logic                w_hazard;
    logic                w_idle;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
        assign w_inc[g] = O_IssueGrant && I_IssueDestWr && (I_IssueDestIdx == IDX_W'(g));
        assign w_dec[g] = I_WBValid && (I_WBDestIdx == IDX_W'(g));

        hazard_pend_counter #(.W(PEND_W)) u_cnt (
            .i_clk   (I_CLOCK),
            .i_rst_n (I_RESET_N),
            .i_inc   (w_inc[g]),
            .i_dec   (w_dec[g]),
            .o_cnt   (w_cnt[g]),
            .o_busy  (O_Busy[g]),
            .o_full  (w_full[g])
        );
    end

    // A source whose last pending write retires this cycle is read write-first.
    always_comb begin
        w_src1_haz = I_IssueSrc1Used && O_Busy[I_IssueSrc1Idx]
                     && !((w_cnt[I_IssueSrc1Idx] == PEND_W'(1)) && I_WBValid
                          && (I_WBDestIdx == I_IssueSrc1Idx));
        w_src2_haz = I_IssueSrc2Used && O_Busy[I_IssueSrc2Idx]
                     && !((w_cnt[I_IssueSrc2Idx] == PEND_W'(1)) && I_WBValid
                          && (I_WBDestIdx == I_IssueSrc2Idx));
        w_dest_haz = I_IssueDestWr && w_full[I_IssueDestIdx];
        w_hazard   = w_src1_haz || w_src2_haz || w_dest_haz;
    end

    assign w_idle       = I_RESET_N && (r_state == ST_IDLE);
    assign O_IssueGrant = I_IssueValid && !w_hazard && w_idle;
    assign O_DepStall   = I_IssueValid && w_hazard && w_idle;
    assign O_Flush      = (r_state == ST_FLUSH);
    assign O_BrTimeout  = r_timeout;

`ifdef HAZARD_BR_PREDICT_EN
    assign O_FetchStall = O_DepStall;
`else
    assign O_FetchStall = O_DepStall || (r_state == ST_BR_PEND);
`endif

    assign w_to_inc = r_to_cnt + TO_W'(1);

    // Branch FSM next-state; the timeout counter saturates at BR_TIMEOUT.
    always_comb begin
        w_state_nxt   = r_state;
        w_to_cnt_nxt  = r_to_cnt;
        w_timeout_nxt = r_timeout;
        case (r_state)
            ST_IDLE: begin
                if (O_IssueGrant && I_IssueIsBranch) begin
                    w_state_nxt  = ST_BR_PEND;
                    w_to_cnt_nxt = '0;
                end
            end
            ST_BR_PEND: begin
                if (I_BrResolve) begin
                    w_state_nxt = I_BrTaken ? ST_FLUSH : ST_IDLE;
                end else if (r_to_cnt != TO_MAX) begin
                    w_to_cnt_nxt = w_to_inc;
                    if (w_to_inc == TO_MAX) begin
                        w_timeout_nxt = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_state   <= ST_IDLE;
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: one table row per clock cycle plus timeout/reset sequences.
module tb_hazard_ctrl;

`ifdef HAZARD_BR_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic [3:0] s1;
        logic       s1u;
        logic [3:0] s2;
        logic       s2u;
        logic [3:0] d;
        logic       dw;
        logic       br;
        logic       wbv;
        logic [3:0] wbd;
        logic       brr;
        logic       brt;
        logic       eg;
        logic       ed;
        logic       ep;
        logic       ef;
        logic [15:0] eb;
        logic       et;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        iv, s1u, s2u, dw, br, wbv, brr, brt;
    logic [3:0]  s1, s2, d, wbd;
    logic        grant, dep, fstall, flush, tmo;
    logic [15:0] busy;

    int nchk = 0;
    int nerr = 0;
    vec_t vq[$];

    hazard_ctrl dut (
        .I_CLOCK         (clk),
        .I_RESET_N       (rst_n),
        .I_IssueValid    (iv),
        .I_IssueSrc1Idx  (s1),
        .I_IssueSrc2Idx  (s2),
        .I_IssueSrc1Used (s1u),
        .I_IssueSrc2Used (s2u),
        .I_IssueDestIdx  (d),
        .I_IssueDestWr   (dw),
        .I_IssueIsBranch (br),
        .I_WBValid       (wbv),
        .I_WBDestIdx     (wbd),
        .I_BrResolve     (brr),
        .I_BrTaken       (brt),
        .O_IssueGrant    (grant),
        .O_DepStall      (dep),
        .O_FetchStall    (fstall),
        .O_Flush         (flush),
        .O_Busy          (busy),
        .O_BrTimeout     (tmo)
    );

    // State updates on negedge; inputs change on posedge and are checked 1 time unit later.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic vec_t mk(input bit v_, input int s1_, input bit s1u_, input int s2_, input bit s2u_,
                                input int d_, input bit dw_, input bit br_, input bit wbv_, input int wbd_,
                                input bit brr_, input bit brt_, input bit eg_, input bit ed_, input bit ep_,
                                input bit ef_, input logic [15:0] eb_, input bit et_);
        vec_t x;
        x.v = v_;   x.s1 = 4'(s1_); x.s1u = s1u_; x.s2 = 4'(s2_); x.s2u = s2u_;
        x.d = 4'(d_); x.dw = dw_; x.br = br_; x.wbv = wbv_; x.wbd = 4'(wbd_);
        x.brr = brr_; x.brt = brt_;
        x.eg = eg_; x.ed = ed_; x.ep = ep_; x.ef = ef_; x.eb = eb_; x.et = et_;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        iv = x.v; s1 = x.s1; s1u = x.s1u; s2 = x.s2; s2u = x.s2u;
        d = x.d; dw = x.dw; br = x.br; wbv = x.wbv; wbd = x.wbd;
        brr = x.brr; brt = x.brt;
    endtask

    task automatic idle_in();
        iv = 0; s1 = 0; s1u = 0; s2 = 0; s2u = 0; d = 0; dw = 0; br = 0;
        wbv = 0; wbd = 0; brr = 0; brt = 0;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    // ep = branch pending: holds Fetch only when prediction is off.
    task automatic chk_outs(input int idx, input bit eg, input bit ed, input bit ep, input bit ef,
                            input logic [15:0] eb, input bit et);
        chk("grant", idx, 32'(grant), 32'(eg));
        chk("depstall", idx, 32'(dep), 32'(ed));
        chk("fetchstall", idx, 32'(fstall), 32'(ed | (ep & ~PRED)));
        chk("flush", idx, 32'(flush), 32'(ef));
        chk("busy", idx, 32'(busy), 32'(eb));
        chk("timeout", idx, 32'(tmo), 32'(et));
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        #1;
        chk_outs(0, 0, 0, 0, 0, 16'h0000, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // v s1 u s2 u d dw br wbv wbd brr brt | grant dep pend flush busy tmo
        // RAW on R3, released zero-bubble by the R3 writeback
        vq.push_back(mk(1,0,0,0,0,3,1,0,0,0,0,0, 1,0,0,0,16'h0000,0));
        vq.push_back(mk(1,3,1,0,0,4,1,0,0,0,0,0, 0,1,0,0,16'h0008,0));
        vq.push_back(mk(1,0,0,3,1,4,1,0,0,0,0,0, 0,1,0,0,16'h0008,0));
        vq.push_back(mk(1,3,1,0,0,4,1,0,1,3,0,0, 1,0,0,0,16'h0008,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,1,4,0,0, 0,0,0,0,16'h0010,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,16'h0000,0));
        // R5 saturates at 3; full counter stalls a write even while retiring
        vq.push_back(mk(1,0,0,0,0,5,1,0,0,0,0,0, 1,0,0,0,16'h0000,0));
        vq.push_back(mk(1,0,0,0,0,5,1,0,0,0,0,0, 1,0,0,0,16'h0020,0));
        vq.push_back(mk(1,0,0,0,0,5,1,0,0,0,0,0, 1,0,0,0,16'h0020,0));
        vq.push_back(mk(1,0,0,0,0,5,1,0,0,0,0,0, 0,1,0,0,16'h0020,0));
        vq.push_back(mk(1,0,0,0,0,5,1,0,1,5,0,0, 0,1,0,0,16'h0020,0));
        vq.push_back(mk(1,0,0,0,0,5,1,0,0,0,0,0, 1,0,0,0,16'h0020,0));
        vq.push_back(mk(1,0,0,0,0,5,1,0,0,0,0,0, 0,1,0,0,16'h0020,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,1,5,0,0, 0,0,0,0,16'h0020,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,1,5,0,0, 0,0,0,0,16'h0020,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,1,5,0,0, 0,0,0,0,16'h0020,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,1,5,0,0, 0,0,0,0,16'h0000,0));
        vq.push_back(mk(1,5,1,0,0,0,0,0,0,0,0,0, 1,0,0,0,16'h0000,0));
        // same-cycle inc/dec on R2 leaves count at 1
        vq.push_back(mk(1,0,0,0,0,2,1,0,0,0,0,0, 1,0,0,0,16'h0000,0));
        vq.push_back(mk(1,0,0,0,0,2,1,0,1,2,0,0, 1,0,0,0,16'h0004,0));
        vq.push_back(mk(1,2,1,0,0,0,0,0,0,0,0,0, 0,1,0,0,16'h0004,0));
        vq.push_back(mk(1,2,1,0,0,0,0,0,1,2,0,0, 1,0,0,0,16'h0004,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,16'h0000,0));
        // taken branch: 3 cycles pending, one flush cycle, resolve in FLUSH ignored
        vq.push_back(mk(1,0,0,0,0,0,0,1,0,0,0,0, 1,0,0,0,16'h0000,0));
        vq.push_back(mk(1,0,0,0,0,1,1,0,0,0,0,0, 0,0,1,0,16'h0000,0));
        vq.push_back(mk(1,0,0,0,0,1,1,0,0,0,0,0, 0,0,1,0,16'h0000,0));
        vq.push_back(mk(1,0,0,0,0,1,1,0,0,0,1,1, 0,0,1,0,16'h0000,0));
        vq.push_back(mk(1,0,0,0,0,1,1,0,0,0,1,1, 0,0,0,1,16'h0000,0));
        vq.push_back(mk(1,0,0,0,0,1,1,0,0,0,0,0, 1,0,0,0,16'h0000,0));
        // JSR writes R6; not-taken resolve; resolve in IDLE ignored
        vq.push_back(mk(1,0,0,0,0,6,1,1,1,1,0,0, 1,0,0,0,16'h0002,0));
        vq.push_back(mk(1,6,1,0,0,0,0,0,0,0,1,0, 0,0,1,0,16'h0040,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,1,6,1,1, 0,0,0,0,16'h0040,0));
        vq.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,16'h0000,0));

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            drive(vq[i]);
            #1;
            chk_outs(100 + i, vq[i].eg, vq[i].ed, vq[i].ep, vq[i].ef, vq[i].eb, vq[i].et);
        end

        // R7 pending, then a branch that never resolves
        @(posedge clk);
        idle_in(); iv = 1; d = 7; dw = 1;
        #1 chk_outs(200, 1, 0, 0, 0, 16'h0000, 0);
        @(posedge clk);
        idle_in(); iv = 1; br = 1;
        #1 chk_outs(201, 1, 0, 0, 0, 16'h0080, 0);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            idle_in();
            #1 chk_outs(210 + k, 0, 0, 1, 0, 16'h0080, (k >= 16));
        end

        // asynchronous reset mid-cycle while pending and timed out
        @(posedge clk);
        idle_in(); iv = 1; s1 = 7; s1u = 1;
        #2 rst_n = 1'b0;
        #1 chk_outs(300, 0, 0, 0, 0, 16'h0000, 0);
        @(negedge clk);
        #1 chk_outs(301, 0, 0, 0, 0, 16'h0000, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk_outs(302, 1, 0, 0, 0, 16'h0000, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            idle_in();
            #1 chk_outs(310 + k, 0, 0, 0, 0, 16'h0000, 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that sequences issue from Decode into Execute. It keeps a per-register scoreboard of in-flight destination writes and stalls dependent instructions via O_DepStall. It also runs a branch state machine that holds Fetch and raises a flush when a taken branch resolves. It sits beside Decode and drives the same stall signals Execute forwards down the pipe.

## Interface
- NUM_REGS, 16, architectural registers tracked
- PEND_W, 2, width of each per-register pending-write counter
- BR_TIMEOUT, 15, cycles in BR_PEND before O_BrTimeout is set
- I_CLOCK  in  1  pipeline clock; all state updates on negedge, matching the pipeline stages
- I_RESET_N  in  1  reset, asynchronous, active-low
- I_IssueValid  in  1  Decode holds a valid instruction
- I_IssueSrc1Idx / I_IssueSrc2Idx  in  4 each  source register indices
- I_IssueSrc1Used / I_IssueSrc2Used  in  1 each  source is actually read
- I_IssueDestIdx  in  4  destination register index
- I_IssueDestWr  in  1  instruction writes its destination
- I_IssueIsBranch  in  1  instruction is BR*/JSR
- I_WBValid  in  1  Writeback retires a register write this cycle
- I_WBDestIdx  in  4  register being retired
- I_BrResolve  in  1  branch outcome is known this cycle
- I_BrTaken  in  1  qualifies I_BrResolve
- O_IssueGrant  out  1  instruction advances to Execute this cycle
- O_DepStall  out  1  data-hazard stall
- O_FetchStall  out  1  Fetch must hold PC
- O_Flush  out  1  kill Fetch/Decode contents
- O_Busy  out  NUM_REGS  bit i set when counter i is non-zero
- O_BrTimeout  out  1  sticky: a branch never resolved

## Operation
- Scoreboard: one PEND_W-bit counter per register.
  - Issue with I_IssueDestWr increments the counter for I_IssueDestIdx.
  - I_WBValid decrements the counter for I_WBDestIdx.
  - An increment and a decrement to the same index in the same cycle leave the counter unchanged.
  - A decrement of a counter at 0 is ignored.
- Hazard, evaluated combinationally in the current cycle. A used source is a hazard when its counter is non-zero, unless the counter is 1 and that register is retiring this cycle (write-first register file). An issue with I_IssueDestWr is also a hazard when its destination counter is saturated (all ones).
- O_DepStall = I_IssueValid & hazard & (state==IDLE).
- O_IssueGrant = I_IssueValid & ~hazard & (state==IDLE).
- Branch state machine:
  - IDLE: a granted issue with I_IssueIsBranch goes to BR_PEND and clears the timeout counter.
  - BR_PEND: issue is blocked. I_BrResolve & I_BrTaken goes to FLUSH. I_BrResolve & ~I_BrTaken goes to IDLE. Otherwise the timeout counter increments; when it reaches BR_TIMEOUT, O_BrTimeout is set (sticky until reset) and the state stays BR_PEND.
  - FLUSH: O_Flush=1 for exactly one cycle, then IDLE.
- I_BrResolve in IDLE or FLUSH is ignored.
- O_FetchStall = O_DepStall | (state==BR_PEND), subject to the macro below.

## Timing
- Reset (asynchronous assertion, takes effect immediately):
  - all counters 0 and O_Busy=0
  - state IDLE
  - O_IssueGrant=0, O_DepStall=0, O_FetchStall=0, O_Flush=0, O_BrTimeout=0
- Reset mid-branch or with writes pending discards all state; no flush is emitted.
- O_IssueGrant, O_DepStall and O_FetchStall are combinational. Counters, state and O_BrTimeout update on negedge I_CLOCK.
- O_Flush is decoded from state and is asserted during the cycle after the resolving negedge.
- A dependent instruction issues on the same edge its producer retires: zero-bubble write-first.
- Minimum branch penalty: 1 cycle in BR_PEND, plus 1 cycle of FLUSH if taken.
- A branch that also writes (JSR) increments its destination counter on the granting edge.

## Configuration
- HAZARD_BR_PREDICT_EN defined:
  - predict not-taken; O_FetchStall ignores state BR_PEND, so Fetch runs ahead;
  - issue is still blocked in BR_PEND;
  - a taken resolve flushes as above, and a not-taken resolve loses no cycles.
- HAZARD_BR_PREDICT_EN undefined: O_FetchStall=1 throughout BR_PEND; FLUSH still occurs for taken branches.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (IDLE, BR_PEND, FLUSH)
  - the NUM_REGS and PEND_W defaults
  - the timeout counter width, derived from BR_TIMEOUT
- Opcode widths come from global_def.h.
- One sub-module, hazard_pend_counter: a PEND_W-bit saturating up/down counter with inc, dec, busy and full outputs, instantiated NUM_REGS times.

## Test plan
- Issue ADD with dest R3, then ADD with src1 R3 on the next cycle, with no writeback → second instruction sees O_DepStall=1 and O_FetchStall=1, O_IssueGrant=0 until the cycle I_WBValid with I_WBDestIdx=3 fires, and is granted that same cycle.
- Issue three writes to R5 with no retire (PEND_W=2) → counter reaches 3, and a fourth write to R5 stalls. One retire of R5 → the fourth write is granted and the counter returns to 3.
- Same-cycle issue of a write to R2 with a retire of R2 while the counter is 1 → counter stays 1 and O_Busy[2]=1.
- BRZ issued, then I_BrResolve=1 with I_BrTaken=1 after 3 cycles → 3 cycles BR_PEND, then O_Flush=1 for one cycle, then IDLE. O_FetchStall is 1 in BR_PEND only when HAZARD_BR_PREDICT_EN is undefined.
- Branch issued and never resolved with BR_TIMEOUT=15 → O_BrTimeout rises after 15 cycles in BR_PEND and stays high. Asserting I_RESET_N=0 then clears all outputs asynchronously.
- Reset asserted while R7 is pending and in BR_PEND → O_Busy=0, state IDLE, O_Flush never pulses, and the next instruction using R7 is granted immediately.
